dsp_mac_pipe: RTL
=================

# dsp_mac_pipe

Parametrised, pipelined multiply-accumulate element that generalises our simplified DSP48E1 behavioural MAC to configurable operand and accumulator widths. It adds selectable signed/unsigned arithmetic, a per-operation opcode (multiply, multiply-add, accumulate, subtract-accumulate), valid tracking through the pipeline, a global clock enable, and saturation with an overflow flag. It is the processing element instantiated in each cell of the systolic array, and it is also the simulation stand-in wherever a DSP slice is inferred.

## Interface

Parameters:
- A_W, 8, width of operand A.
- B_W, 8, width of operand B.
- ACC_W, 32, width of the accumulator, C input and P output. Must satisfy ACC_W >= A_W+B_W; elaboration fails otherwise.
- SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- CLK, input, 1, single clock. All logic is rising-edge.
- RST, input, 1, asynchronous, active-high reset.
- CE, input, 1, global clock enable. When 0, every register holds.
- in_valid, input, 1, qualifies A, B, C and OPMODE.
- A, input, A_W, multiplicand.
- B, input, B_W, multiplier.
- C, input, ACC_W, addend. Used only by OPMODE 01.
- OPMODE, input, 2, operation select: 00 P=A*B; 01 P=A*B+C; 10 P=P+A*B; 11 P=P-A*B.
- P, output, ACC_W, result and accumulator register.
- out_valid, output, 1, P holds a new result this cycle.
- OVERFLOW, output, 1, the result in P overflowed. Aligned with out_valid.

## Operation

- Three register stages, each advancing only when CE=1.
- Stage 1 (input): registers A, B, C, OPMODE and in_valid.
- Stage 2 (multiply): registers the product M (A_W+B_W bits), plus the delayed C, OPMODE and valid. The product is signed when SIGNED=1 and unsigned otherwise.
- Stage 3 (accumulate): if the stage-2 valid is 1, computes the selected operation and writes P, sets out_valid=1 and writes OVERFLOW.
  - If the stage-2 valid is 0 (a bubble), P and OVERFLOW hold and out_valid=0.
- Arithmetic width rules:
  - M, C and P are sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W+2 bits before the add or subtract.
  - The accumulate feedback source is the P register itself.
- Range check. The representable range is [-2^(ACC_W-1), 2^(ACC_W-1)-1] when signed and [0, 2^ACC_W-1] when unsigned.
  - Out of range with SATURATE=1: P takes the nearest bound.
  - Out of range with SATURATE=0: P takes the low ACC_W bits.
  - In both cases OVERFLOW=1 for that result; otherwise OVERFLOW=0.
- OVERFLOW is per-result, not sticky.
- Unsigned subtract below 0 saturates to 0 when SATURATE=1.
- OPMODE 00 or 01 restarts accumulation. No separate clear input exists.

## Timing

- Reset values: P=0, out_valid=0, OVERFLOW=0, and all pipeline registers 0 (including the stage valids). Reset takes effect immediately and asynchronously.
- Latency: an input sampled at a CE=1 edge n produces its result on P/out_valid after edge n+2, so it is visible in the cycle following the third qualifying edge.
- Throughput: one operation per CE=1 cycle.
- Back-to-back OPMODE 10/11 operations accumulate correctly every cycle with no hazard, because the feedback is taken from P.
- CE=0: the whole pipeline freezes. out_valid, P and OVERFLOW hold their current values. A result therefore stays visible for exactly one CE=1 cycle plus any stalled cycles.
- Reset mid-operation discards all in-flight operations. The first valid result after reset appears three CE=1 edges after a new in_valid.
- Simultaneous in_valid=1 with CE=0: the input is ignored and not captured.

## Test plan

- Signed multiply (defaults), OPMODE 00, A=-3, B=5 -> after 3 edges P=-15 (0xFFFFFFF1), out_valid=1 for one cycle, OVERFLOW=0.
- Accumulate chain: OPMODE 00 with 2*3, then OPMODE 10 with 4*5, then OPMODE 11 with 1*7, back-to-back -> P sequence 6, 26, 19 on three consecutive cycles. Then OPMODE 01 with A=1, B=1, C=100 -> P=101.
- Saturation with A_W=B_W=8, ACC_W=16, SIGNED=1, SATURATE=1: OPMODE 00 with 127*127, then 10 with 127*127 twice -> P=16129, then 32258, then 32767 with OVERFLOW=1. Repeat with SATURATE=0 -> third P=-17149 (wrapped), OVERFLOW=1.
- Unsigned, SIGNED=0: A=255, B=255, OPMODE 00 -> P=65025. Then OPMODE 11 with 255*255 twice -> P=0, then P=0 with OVERFLOW=1 (saturated).
- CE and bubbles: issue 3 valid ops with in_valid gaps, and drop CE for 2 cycles mid-stream -> results appear in order with no loss or duplication. P holds during the stall, and out_valid=0 for each bubble.
- Reset mid-operation: assert RST one cycle after issuing two valid ops -> P=0 and out_valid=0 immediately, and no result from the discarded ops ever appears.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: three-stage multiply-accumulate with signed/unsigned arithmetic, opcode select and saturation
module dsp_mac_pipe #(
  parameter int A_W = 8,
  parameter int B_W = 8,
  parameter int ACC_W = 32,
  parameter int SIGNED = 1,
  parameter int SATURATE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             in_valid,
  input  logic [A_W-1:0]   A,
  input  logic [B_W-1:0]   B,
  input  logic [ACC_W-1:0] C,
  input  logic [1:0]       OPMODE,
  output logic [ACC_W-1:0] P,
  output logic             out_valid,
  output logic             OVERFLOW
);
  localparam int MW = A_W + B_W;
  localparam int EW = ACC_W + 2;
  generate
    if (ACC_W < MW) begin : g_bad_width
      $error("dsp_mac_pipe: ACC_W must be >= A_W+B_W");
    end
  endgenerate
  logic [A_W-1:0]   a_r;
  logic [B_W-1:0]   b_r;
  logic [ACC_W-1:0] c_r, c2_r;
  logic [1:0]       op_r, op2_r;
  logic             v1_r, v2_r;
  logic [MW-1:0]    m_r;
  logic signed [MW-1:0] prod_s;
  logic [MW-1:0]    prod_u, prod;
  logic [EW-1:0]    m_x, c_x, p_x, sum;
  logic             ms, cs, ps, neg, ovf;
  logic [ACC_W-1:0] bound, p_nxt;
  // all-signed operands so the multiply sign-extends into the full product width
  assign prod_s = $signed(a_r) * $signed(b_r);
  assign prod_u = a_r * b_r;
  assign prod = (SIGNED != 0) ? prod_s : prod_u;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
      op_r <= '0;
      v1_r <= 1'b0;
      m_r <= '0;
      c2_r <= '0;
      op2_r <= '0;
      v2_r <= 1'b0;
    end else if (CE) begin
      a_r <= A;
      b_r <= B;
      c_r <= C;
      op_r <= OPMODE;
      v1_r <= in_valid;
      m_r <= prod;
      c2_r <= c_r;
      op2_r <= op_r;
      v2_r <= v1_r;
    end
  end
  always_comb begin
    ms = (SIGNED != 0) && m_r[MW-1];
    cs = (SIGNED != 0) && c2_r[ACC_W-1];
    ps = (SIGNED != 0) && P[ACC_W-1];
    m_x = {{(EW-MW){ms}}, m_r};
    c_x = {{2{cs}}, c2_r};
    p_x = {{2{ps}}, P};
    sum = (op2_r == 2'b00) ? m_x :
          (op2_r == 2'b01) ? m_x + c_x :
          (op2_r == 2'b10) ? p_x + m_x : p_x - m_x;
    neg = sum[EW-1];
    // signed fits when the bits above the result sign all agree; unsigned when they are all zero
    ovf = (SIGNED != 0) ? !((&sum[EW-1:ACC_W-1]) || !(|sum[EW-1:ACC_W-1])) : |sum[EW-1:ACC_W];
    bound = (SIGNED != 0) ? (neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                          : (neg ? {ACC_W{1'b0}} : {ACC_W{1'b1}});
    p_nxt = (ovf && SATURATE != 0) ? bound : sum[ACC_W-1:0];
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P <= '0;
      out_valid <= 1'b0;
      OVERFLOW <= 1'b0;
    end else if (CE) begin
      out_valid <= v2_r;
      if (v2_r) begin
        P <= p_nxt;
        OVERFLOW <= ovf;
      end
    end
  end
endmodule
